// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter bundle: functional-unit result handshake plus the
// registered broadcast bus that feeds the reservation stations.
// master: the functional-unit / consumer side. slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int N_REQ      = 5
);
  localparam int RS_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]                 done_i;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]                 ready_o;
  logic                             flush_i;
  logic [N_REQ-1:0]                 grant_o;
  logic                             bcast_en_o;
  logic [DATA_WIDTH-1:0]            bcast_data_o;
  logic [RS_W-1:0]                  bcast_rs_o;
  logic [CNT_W-1:0]                 pending_cnt_o;

  modport slave (
    input  done_i, data_i, flush_i,
    output ready_o, grant_o, bcast_en_o, bcast_data_o, bcast_rs_o, pending_cnt_o
  );

  modport master (
    output done_i, data_i, flush_i,
    input  ready_o, grant_o, bcast_en_o, bcast_data_o, bcast_rs_o, pending_cnt_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding slot per functional unit, round-robin
// selection of at most one slot per cycle, registered CDB broadcast.
// bcast_rs_o carries the e_functional_unit encoding of the winning slot.
// Optional feature: define CDB_BYPASS_EN to let an empty slot whose unit is
// presenting a result compete directly (1-cycle minimum latency).
module cdb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int N_REQ      = 5
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int RS_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]                 pending_q, pending_d;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic [RS_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                             bcast_en_q, bcast_en_d;
  logic [DATA_WIDTH-1:0]            bcast_data_q, bcast_data_d;
  logic [RS_W-1:0]                  bcast_rs_q, bcast_rs_d;

  logic [N_REQ-1:0]      cand;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      ready;
  logic [N_REQ-1:0]      bypass;
  logic                  win_vld;
  logic [RS_W-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic [CNT_W-1:0]      cnt;

  // Candidate slots: held results, plus live results into empty slots when bypass is built in.
  always_comb begin
    cand = pending_q;
`ifdef CDB_BYPASS_EN
    if (!bus.flush_i) cand = pending_q | bus.done_i;
`endif
  end

  // Round-robin search starting at rr_ptr, ascending with wrap; first candidate wins.
  always_comb begin
    int        idx;
    logic [RS_W-1:0] idx_w;
    idx     = 0;
    idx_w   = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = int'(rr_ptr_q) + j;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = RS_W'(idx);
      if (!win_vld && cand[idx_w]) begin
        win_vld = 1'b1;
        win_idx = idx_w;
      end
    end
  end

  // Grant/ready decode and winning-data mux; flush squashes both grant and ready.
  always_comb begin
    grant    = '0;
    bypass   = '0;
    win_data = slot_data_q[win_idx];
    if (win_vld && !bus.flush_i) grant[win_idx] = 1'b1;
`ifdef CDB_BYPASS_EN
    if (!pending_q[win_idx]) win_data = bus.data_i[win_idx];
    bypass = grant & ~pending_q;
`endif
    ready = bus.flush_i ? '0 : (~pending_q | grant);
  end

  // Next-state: slot capture/release, pointer advance and broadcast load.
  always_comb begin
    pending_d    = pending_q;
    slot_data_d  = slot_data_q;
    rr_ptr_d     = rr_ptr_q;
    bcast_en_d   = 1'b0;
    bcast_data_d = bcast_data_q;
    bcast_rs_d   = bcast_rs_q;
    if (bus.flush_i) begin
      pending_d = '0;
    end else begin
      // A granted slot that is refilled in the same cycle stays occupied.
      pending_d = (pending_q & ~grant) | (bus.done_i & ready & ~bypass);
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.done_i[i] && ready[i]) slot_data_d[i] = bus.data_i[i];
      end
      if (|grant) begin
        bcast_en_d   = 1'b1;
        bcast_data_d = win_data;
        bcast_rs_d   = win_idx;
        rr_ptr_d     = (int'(win_idx) + 1 == N_REQ) ? '0 : win_idx + RS_W'(1);
      end
    end
  end

  // Control state and broadcast registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      bcast_en_q   <= 1'b0;
      bcast_data_q <= '0;
      bcast_rs_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      bcast_en_q   <= bcast_en_d;
      bcast_data_q <= bcast_data_d;
      bcast_rs_q   <= bcast_rs_d;
    end
  end

  // Slot payloads need no reset: they are only observed through pending.
  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
  end

  // Occupancy count is the popcount of the registered pending vector.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) cnt = cnt + CNT_W'(pending_q[i]);
  end

  assign bus.ready_o       = ready;
  assign bus.grant_o       = grant;
  assign bus.bcast_en_o    = bcast_en_q;
  assign bus.bcast_data_o  = bcast_data_q;
  assign bus.bcast_rs_o    = bcast_rs_q;
  assign bus.pending_cnt_o = cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (default build, 5 requesters).
// Each row drives done/flush/data on the falling edge and checks the outputs
// visible in that same cycle; slot i receives data value dval + i.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int DW = 64;
  localparam int NV = 29;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  cdb_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();

  cdb_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  done;
    logic          flush;
    logic [DW-1:0] dval;
    logic [N-1:0]  er;
    logic [N-1:0]  eg;
    logic          eb;
    logic [DW-1:0] ed;
    logic [2:0]    ers;
    logic [2:0]    ec;
  } vec_t;

  vec_t vt [NV];

  task automatic drive(input logic [N-1:0] d, input logic f, input logic [DW-1:0] dv);
    bus.done_i  = d;
    bus.flush_i = f;
    for (int i = 0; i < N; i++) bus.data_i[i] = dv + DW'(i);
  endtask

  task automatic check(input string name, input logic [N-1:0] er, input logic [N-1:0] eg,
                       input logic eb, input logic [DW-1:0] ed, input logic [2:0] ers,
                       input logic [2:0] ec);
    n_vec++;
    if (bus.ready_o !== er || bus.grant_o !== eg || bus.bcast_en_o !== eb ||
        bus.bcast_data_o !== ed || bus.bcast_rs_o !== ers || bus.pending_cnt_o !== ec) begin
      n_bad++;
      $display("FAIL %s: got ready=%b grant=%b en=%b data=%h rs=%0d cnt=%0d, want ready=%b grant=%b en=%b data=%h rs=%0d cnt=%0d",
               name, bus.ready_o, bus.grant_o, bus.bcast_en_o, bus.bcast_data_o,
               bus.bcast_rs_o, bus.pending_cnt_o, er, eg, eb, ed, ers, ec);
    end
  endtask

  // Watchdog: the run is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    drive('0, 1'b0, '0);

    //            done      fl   dval                ready     grant     en   bdata               rs    cnt
    // reset state, then single request on slot 2 (broadcast two cycles later, one cycle wide)
    vt[0]  = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b0, 64'h0,             3'd0, 3'd0};
    vt[1]  = '{5'b00100, 1'b0, 64'hDEAD_BEED,     5'b11111, 5'b00000, 1'b0, 64'h0,             3'd0, 3'd0};
    vt[2]  = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00100, 1'b0, 64'h0,             3'd0, 3'd1};
    vt[3]  = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b1, 64'hDEAD_BEEF,     3'd2, 3'd0};
    vt[4]  = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b0, 64'hDEAD_BEEF,     3'd2, 3'd0};
    // move rr_ptr to 4 via slot 3, refill all slots, then drain 4,0,1,2,3
    vt[5]  = '{5'b01000, 1'b0, 64'h100,           5'b11111, 5'b00000, 1'b0, 64'hDEAD_BEEF,     3'd2, 3'd0};
    vt[6]  = '{5'b11111, 1'b0, 64'h200,           5'b11111, 5'b01000, 1'b0, 64'hDEAD_BEEF,     3'd2, 3'd1};
    vt[7]  = '{5'b00000, 1'b0, 64'h0,             5'b10000, 5'b10000, 1'b1, 64'h103,           3'd3, 3'd5};
    vt[8]  = '{5'b00000, 1'b0, 64'h0,             5'b10001, 5'b00001, 1'b1, 64'h204,           3'd4, 3'd4};
    vt[9]  = '{5'b00000, 1'b0, 64'h0,             5'b10011, 5'b00010, 1'b1, 64'h200,           3'd0, 3'd3};
    vt[10] = '{5'b00000, 1'b0, 64'h0,             5'b10111, 5'b00100, 1'b1, 64'h201,           3'd1, 3'd2};
    vt[11] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b01000, 1'b1, 64'h202,           3'd2, 3'd1};
    vt[12] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b1, 64'h203,           3'd3, 3'd0};
    vt[13] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b0, 64'h203,           3'd3, 3'd0};
    // refill on grant: slot 0 granted while a new slot-0 result arrives
    vt[14] = '{5'b00001, 1'b0, 64'h300,           5'b11111, 5'b00000, 1'b0, 64'h203,           3'd3, 3'd0};
    vt[15] = '{5'b00001, 1'b0, 64'h310,           5'b11111, 5'b00001, 1'b0, 64'h203,           3'd3, 3'd1};
    vt[16] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00001, 1'b1, 64'h300,           3'd0, 3'd1};
    vt[17] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b1, 64'h310,           3'd0, 3'd0};
    // backpressure: slot 1 occupied and losing to slot 3 while unit 1 holds 5
    vt[18] = '{5'b00110, 1'b0, 64'h400,           5'b11111, 5'b00000, 1'b0, 64'h310,           3'd0, 3'd0};
    vt[19] = '{5'b00000, 1'b0, 64'h0,             5'b11011, 5'b00010, 1'b0, 64'h310,           3'd0, 3'd2};
    vt[20] = '{5'b01010, 1'b0, 64'h500,           5'b11111, 5'b00100, 1'b1, 64'h401,           3'd1, 3'd1};
    vt[21] = '{5'b00010, 1'b0, 64'h4,             5'b11101, 5'b01000, 1'b1, 64'h402,           3'd2, 3'd2};
    vt[22] = '{5'b00010, 1'b0, 64'h4,             5'b11111, 5'b00010, 1'b1, 64'h503,           3'd3, 3'd1};
    vt[23] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00010, 1'b1, 64'h501,           3'd1, 3'd1};
    vt[24] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b1, 64'h5,             3'd1, 3'd0};
    // flush with 4 slots pending and a new done on slot 3 in the flush cycle
    vt[25] = '{5'b10111, 1'b0, 64'h600,           5'b11111, 5'b00000, 1'b0, 64'h5,             3'd1, 3'd0};
    vt[26] = '{5'b01000, 1'b1, 64'h700,           5'b00000, 5'b00000, 1'b0, 64'h5,             3'd1, 3'd4};
    vt[27] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b0, 64'h5,             3'd1, 3'd0};
    vt[28] = '{5'b00000, 1'b0, 64'h0,             5'b11111, 5'b00000, 1'b0, 64'h5,             3'd1, 3'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vt[k].done, vt[k].flush, vt[k].dval);
      #1;
      check($sformatf("vec%0d", k), vt[k].er, vt[k].eg, vt[k].eb, vt[k].ed, vt[k].ers, vt[k].ec);
    end

    // Mid-run asynchronous reset with three slots pending (rr_ptr is 2 here).
    @(negedge clk);
    drive(5'b01111, 1'b0, 64'h800);
    #1;
    check("rst_load", 5'b11111, 5'b00000, 1'b0, 64'h5, 3'd1, 3'd0);
    @(negedge clk);
    drive('0, 1'b0, '0);
    #1;
    check("rst_first_grant", 5'b10100, 5'b00100, 1'b0, 64'h5, 3'd1, 3'd4);
    @(negedge clk);
    #1;
    check("rst_before", 5'b11100, 5'b01000, 1'b1, 64'h802, 3'd2, 3'd3);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async", 5'b11111, 5'b00000, 1'b0, 64'h0, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    check("rst_held", 5'b11111, 5'b00000, 1'b0, 64'h0, 3'd0, 3'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive('0, 1'b0, '0);
      #1;
      check($sformatf("post_rst%0d", k), 5'b11111, 5'b00000, 1'b0, 64'h0, 3'd0, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
